// File: rtl/adder_pipe_if.sv
// Operand/result stream bundle for adder_pipe: producer-side beat, consumer-side result.
interface adder_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, sat, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, sat, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe.sv
// Pipelined add/sub with carry-in, unsigned saturation and signed overflow.
// The carry chain is cut into STAGES slices; one global advance enable stalls the whole pipe.
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic         ck,
  input  logic         rst_n,
  adder_pipe_if.slave  bus
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] sub_q, sub_d;
  logic [STAGES-1:0] sat_q, sat_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_q, ovf_d;

  logic              adv;
  logic [STAGES-1:0] src_v, src_c, src_sub, src_sat;
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [SW:0]       slice;
  logic [WIDTH-1:0]  res;

  assign adv = !vld_q[STAGES-1] || bus.out_ready;

  // Stage 0 is fed from the port (b pre-inverted for sub), stage k from register k-1.
  always_comb begin
    src_v[0]   = bus.in_valid;
    src_a[0]   = bus.a;
    src_b[0]   = bus.sub ? ~bus.b : bus.b;
    src_c[0]   = bus.sub ? !bus.cin : bus.cin;
    src_sub[0] = bus.sub;
    src_sat[0] = bus.sat;
    src_s[0]   = '0;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]   = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_c[k]   = c_q[k-1];
      src_sub[k] = sub_q[k-1];
      src_sat[k] = sat_q[k-1];
      src_s[k]   = s_q[k-1];
    end
  end

  always_comb begin
    vld_d = vld_q;
    c_d   = c_q;
    sub_d = sub_q;
    sat_d = sat_q;
    a_d   = a_q;
    b_d   = b_q;
    s_d   = s_q;
    ovf_d = ovf_q;
    slice = '0;
    res   = '0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        slice = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
              + {{SW{1'b0}}, src_c[k]};
        res   = src_s[k];
        res[k*SW +: SW] = slice[SW-1:0];
        vld_d[k] = src_v[k];
        a_d[k]   = src_a[k];
        b_d[k]   = src_b[k];
        c_d[k]   = slice[SW];
        sub_d[k] = src_sub[k];
        sat_d[k] = src_sat[k];
        s_d[k]   = res;
        if (k == STAGES - 1) begin
          // carry into the MSB recovered from the MSB sum bit
          ovf_d = src_a[k][WIDTH-1] ^ src_b[k][WIDTH-1] ^ res[WIDTH-1] ^ slice[SW];
          if (src_sat[k]) begin
            if (!src_sub[k] && slice[SW]) begin
              s_d[k] = '1;
            end else if (src_sub[k] && !slice[SW]) begin
              s_d[k] = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      sub_q <= '0;
      sat_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      c_q   <= c_d;
      sub_q <= sub_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
    end
  end

  assign bus.in_ready  = adv && rst_n;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule
